// File: rtl/pbs_pkg.sv
// ---- pbs_pkg: shared types, constants and LFSR step for the battle datapath ----
`default_nettype none

package pbs_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ROLL      = 2'd1,
    APPLY     = 2'd2,
    GAME_OVER = 2'd3
  } state_e;

  localparam logic       P1          = 1'b0;
  localparam logic       P2          = 1'b1;
  localparam logic [3:0] ACCU_ALWAYS = 4'd10;
  localparam logic [3:0] ROLL_MAX    = 4'd9;

  // Fibonacci x^4+x^3+1
  function automatic logic [3:0] lfsr_next(input logic [3:0] l);
    return {l[2:0], l[3] ^ l[2]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/lfsr4.sv
// ---- lfsr4: free-running 4-bit LFSR, loads SEED on reset ----
`default_nettype none

module lfsr4
  import pbs_pkg::*;
#(
  parameter logic [3:0] SEED = 4'b1001
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [3:0] q
);

  logic [3:0] q_d;
  logic [3:0] q_q;

  always_comb begin
    q_d = lfsr_next(q_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= SEED;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

`default_nettype wire

// File: rtl/attack_resolver.sv
// ---- attack_resolver: one battle turn (roll vs accuracy, saturating damage), HP and KO tracking ----
`default_nettype none

module attack_resolver
  import pbs_pkg::*;
#(
  parameter int         HP_W      = 6,
  parameter int         HP_INIT   = 40,
  parameter logic [3:0] LFSR_SEED = 4'b1001
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            attacker,
  input  logic [3:0]      dmg,
  input  logic [3:0]      accu,
  input  logic            new_game,
  output logic            busy,
  output logic            done,
  output logic            hit,
  output logic [HP_W-1:0] hp_p1,
  output logic [HP_W-1:0] hp_p2,
  output logic            game_over,
  output logic            winner
);

  localparam logic [HP_W-1:0] HP_RELOAD = HP_W'(HP_INIT);

  state_e          state_q, state_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            hit_q, hit_d;
  logic [HP_W-1:0] hp_p1_q, hp_p1_d;
  logic [HP_W-1:0] hp_p2_q, hp_p2_d;
  logic            game_over_q, game_over_d;
  logic            winner_q, winner_d;
  logic            atk_q, atk_d;
  logic [3:0]      dmg_q, dmg_d;
  logic [3:0]      accu_q, accu_d;
  logic            ng_pend_q, ng_pend_d;

  logic [3:0]      lfsr;
  logic [3:0]      roll;
  logic            roll_ok;
  logic            hit_nxt;
  logic [HP_W-1:0] def_hp;
  logic [HP_W-1:0] dmg_ext;
  logic [HP_W-1:0] hp_after;
  logic            reload;

  lfsr4 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .q     (lfsr)
  );

  // LFSR never holds 0, so roll spans 0..14; values above ROLL_MAX are re-rolled
  assign roll     = lfsr - 4'd1;
  assign roll_ok  = (roll <= ROLL_MAX);
  assign hit_nxt  = (accu_q >= ACCU_ALWAYS) || (roll < accu_q);
  assign def_hp   = (atk_q == P2) ? hp_p1_q : hp_p2_q;
  assign dmg_ext  = HP_W'(dmg_q);
  assign hp_after = (def_hp > dmg_ext) ? (def_hp - dmg_ext) : '0;

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    hit_d       = hit_q;
    hp_p1_d     = hp_p1_q;
    hp_p2_d     = hp_p2_q;
    game_over_d = game_over_q;
    winner_d    = winner_q;
    atk_d       = atk_q;
    dmg_d       = dmg_q;
    accu_d      = accu_q;
    ng_pend_d   = ng_pend_q;
    reload      = 1'b0;

    case (state_q)
      IDLE: begin
        if (new_game) begin
          reload = 1'b1;
        end else if (start) begin
          atk_d     = attacker;
          dmg_d     = dmg;
          accu_d    = accu;
          busy_d    = 1'b1;
          ng_pend_d = 1'b0;
          state_d   = ROLL;
        end
      end
      ROLL: begin
        ng_pend_d = ng_pend_q | new_game;
        if (roll_ok) begin
          done_d  = 1'b1;
          hit_d   = hit_nxt;
          state_d = APPLY;
          if (hit_nxt) begin
            if (atk_q == P2) hp_p1_d = hp_after;
            else             hp_p2_d = hp_after;
          end
        end
      end
      APPLY: begin
        busy_d    = 1'b0;
        ng_pend_d = 1'b0;
        // A new_game seen mid-turn is honoured only now, after the result was shown
        if (ng_pend_q || new_game) begin
          reload = 1'b1;
        end else if (def_hp == '0) begin
          game_over_d = 1'b1;
          winner_d    = atk_q;
          state_d     = GAME_OVER;
        end else begin
          state_d = IDLE;
        end
      end
      GAME_OVER: begin
        if (new_game) reload = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (reload) begin
      hp_p1_d     = HP_RELOAD;
      hp_p2_d     = HP_RELOAD;
      game_over_d = 1'b0;
      winner_d    = P1;
      hit_d       = 1'b0;
      state_d     = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      hit_q       <= 1'b0;
      hp_p1_q     <= HP_RELOAD;
      hp_p2_q     <= HP_RELOAD;
      game_over_q <= 1'b0;
      winner_q    <= P1;
      atk_q       <= P1;
      dmg_q       <= 4'd0;
      accu_q      <= 4'd0;
      ng_pend_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      hit_q       <= hit_d;
      hp_p1_q     <= hp_p1_d;
      hp_p2_q     <= hp_p2_d;
      game_over_q <= game_over_d;
      winner_q    <= winner_d;
      atk_q       <= atk_d;
      dmg_q       <= dmg_d;
      accu_q      <= accu_d;
      ng_pend_q   <= ng_pend_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign hit       = hit_q;
  assign hp_p1     = hp_p1_q;
  assign hp_p2     = hp_p2_q;
  assign game_over = game_over_q;
  assign winner    = winner_q;

endmodule

`default_nettype wire

// File: tb/tb_attack_resolver.sv
// ---- tb_attack_resolver: directed turns checked against a turn-level battle model ----
`default_nettype none

module tb_attack_resolver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       attacker = 1'b0;
  logic [3:0] dmg = 4'd0;
  logic [3:0] accu = 4'd0;
  logic       new_game = 1'b0;
  logic       busy, done, hit, game_over, winner;
  logic [5:0] hp_p1, hp_p2;

  always #5 clk = ~clk;

  attack_resolver #(.HP_W(6), .HP_INIT(40), .LFSR_SEED(4'b1001)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .attacker  (attacker),
    .dmg       (dmg),
    .accu      (accu),
    .new_game  (new_game),
    .busy      (busy),
    .done      (done),
    .hit       (hit),
    .hp_p1     (hp_p1),
    .hp_p2     (hp_p2),
    .game_over (game_over),
    .winner    (winner)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_done  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int step(input int l);
    return ((l << 1) & 14) | (((l >> 3) ^ (l >> 2)) & 1);
  endfunction

  // Turn-level model: on an accepted start, look ahead through future LFSR
  // values to find how many rolls get rejected and what the accepted roll is.
  int m_lf = 9, m_phase = 0, m_to_done = 0;
  int m_hp1 = 40, m_hp2 = 40;
  int m_busy = 0, m_done = 0, m_hit = 0, m_go = 0, m_win = 0;
  int m_atk = 0, m_dmg = 0, m_pend = 0, m_hitnext = 0, m_rej_total = 0;
  int nl, la, rj;

  task automatic m_reload();
    m_hp1 = 40; m_hp2 = 40; m_go = 0; m_win = 0; m_hit = 0;
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      m_lf = 9; m_phase = 0; m_to_done = 0; m_busy = 0; m_done = 0;
      m_pend = 0; m_reload();
    end else begin
      nl = step(m_lf);
      case (m_phase)
        0: begin
          if (new_game) m_reload();
          else if (start && m_go == 0) begin
            la = nl; rj = 0;
            while (la > 10) begin rj++; la = step(la); end
            m_rej_total += rj;
            m_to_done = rj + 1;
            m_hitnext = ((la - 1) < int'(accu)) ? 1 : 0;
            m_atk = int'(attacker); m_dmg = int'(dmg);
            m_busy = 1; m_pend = 0; m_phase = 1;
          end
        end
        1: begin
          if (new_game) m_pend = 1;
          m_to_done--;
          if (m_to_done == 0) begin
            m_done = 1; m_hit = m_hitnext; m_phase = 2;
            if (m_hitnext == 1) begin
              if (m_atk == 1) m_hp1 = (m_hp1 > m_dmg) ? m_hp1 - m_dmg : 0;
              else            m_hp2 = (m_hp2 > m_dmg) ? m_hp2 - m_dmg : 0;
            end
          end
        end
        default: begin
          m_done = 0; m_busy = 0; m_phase = 0;
          if (m_pend == 1 || new_game) m_reload();
          else if ((m_atk == 1 ? m_hp1 : m_hp2) == 0) begin
            m_go = 1; m_win = m_atk;
          end
        end
      endcase
      m_lf = nl;
    end
  end

  always @(negedge clk) begin
    check("busy", busy, m_busy);
    check("done", done, m_done);
    check("hit", hit, m_hit);
    check("hp_p1", hp_p1, m_hp1);
    check("hp_p2", hp_p2, m_hp2);
    check("game_over", game_over, m_go);
    check("winner", winner, m_go == 1 ? m_win : 0);
    check("lfsr", dut.lfsr, m_lf);
    if (done === 1'b1) n_done++;
  end

  task automatic tick(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic turn(input logic a, input logic [3:0] d, input logic [3:0] ac);
    start = 1'b1; attacker = a; dmg = d; accu = ac;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (!(m_phase == 0 && busy == 1'b0) && k < 20) begin tick(1); k++; end
    if (k >= 20) begin
      n_tests++; n_fail++;
      $display("FAIL turn_timeout: got busy=%0d expected idle within 20 cycles", busy);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

  int exp_hp1[4] = '{29, 18, 7, 0};
  int d0, r0;
  bit found;

  initial begin
    tick(3);
    rst_n = 1'b1;
    // reset values and first LFSR steps from seed 9
    @(negedge clk);
    check("lit_lfsr_1", dut.lfsr, 3);
    check("lit_reset_hp1", hp_p1, 40);
    check("lit_reset_hp2", hp_p2, 40);
    check("lit_reset_busy", busy, 0);
    #1; @(negedge clk);
    check("lit_lfsr_2", dut.lfsr, 6);
    #1; @(negedge clk);
    check("lit_lfsr_3", dut.lfsr, 13);
    #1;

    turn(1'b0, 4'd11, 4'd10);
    wait_idle();
    check("lit_t2_hp2", hp_p2, 29);
    check("lit_t2_hp1", hp_p1, 40);
    check("lit_t2_hit", hit, 1);

    // start held into ROLL must be dropped
    d0 = n_done;
    start = 1'b1; attacker = 1'b0; dmg = 4'd15; accu = 4'd0;
    tick(2);
    start = 1'b0;
    wait_idle();
    tick(3);
    check("lit_t3_one_done", n_done - d0, 1);
    check("lit_t3_hit", hit, 0);
    check("lit_t3_hp2", hp_p2, 29);

    for (int i = 0; i < 4; i++) begin
      turn(1'b1, 4'd11, 4'd10);
      wait_idle();
      check("lit_t4_hp1", hp_p1, exp_hp1[i]);
    end
    check("lit_t4_go", game_over, 1);
    check("lit_t4_winner", winner, 1);
    turn(1'b0, 4'd5, 4'd10);
    tick(5);
    check("lit_t4_ignored_hp2", hp_p2, 29);
    check("lit_t4_ignored_busy", busy, 0);

    new_game = 1'b1; tick(1); new_game = 1'b0; tick(1);
    check("lit_t5_hp1", hp_p1, 40);
    check("lit_t5_hp2", hp_p2, 40);
    check("lit_t5_go", game_over, 0);

    // new_game during ROLL: result shows first, reload the cycle after done
    turn(1'b0, 4'd3, 4'd10);
    new_game = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        found = 1'b1;
        check("lit_t5_done_hp2", hp_p2, 37);
      end
      #1;
      new_game = 1'b0;
    end
    if (!found) begin
      n_tests++; n_fail++;
      $display("FAIL t5_done_timeout: got no done expected done within 10 cycles");
    end
    @(negedge clk);
    check("lit_t5_after_hp2", hp_p2, 40);
    check("lit_t5_after_busy", busy, 0);
    #1;

    turn(1'b0, 4'd7, 4'd10);
    wait_idle();
    check("lit_t6_hp2", hp_p2, 33);
    d0 = n_done;
    turn(1'b0, 4'd5, 4'd10);
    rst_n = 1'b0;
    @(negedge clk);
    check("lit_t6_rst_busy", busy, 0);
    check("lit_t6_rst_hp2", hp_p2, 40);
    check("lit_t6_rst_lfsr", dut.lfsr, 9);
    #1; rst_n = 1'b1;
    tick(3);
    check("lit_t6_no_done", n_done - d0, 0);

    // vary gaps so accepted starts land on LFSR values that force re-rolls
    r0 = m_rej_total;
    for (int g = 0; g < 16 && m_rej_total == r0; g++) begin
      tick(g % 3);
      turn(g[0], 4'd1, 4'((g * 3) % 11));
      wait_idle();
    end
    check("lit_reject_seen", (m_rej_total > r0) ? 1 : 0, 1);
    tick(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
